// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the two byte producers, the shared uart_tx and uart_tx_arbiter.
// The arbiter side uses modport master; producers and uart_tx together use modport slave.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_wr;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_active, tx_done,
        output req0_ready, req1_ready, tx_wr, tx_byte
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data, tx_active, tx_done,
        input  req0_ready, req1_ready, tx_wr, tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between two producers, each behind a DEPTH-entry FIFO.
// Define UART_ARB_CRLF_EN to transmit an extra 8'h0A after every completed 8'h0D frame.
module uart_tx_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus,
    output logic              busy,
    output logic [1:0]        ovf,
    output logic              grant
);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_DONE
`ifdef UART_ARB_CRLF_EN
        ,
        CRLF
`endif
    } state_t;

    state_t          state;
    state_t          after_frame;
    logic            last_grant;
    logic            tx_wr_q;
    logic [7:0]      tx_byte_q;

    logic [1:0]      valid;
    logic [1:0]      ready;
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      empty;
    logic [1:0][7:0] din;
    logic [1:0][7:0] head;
    logic            sel;
    logic            load;

    assign valid          = {bus.req1_valid, bus.req0_valid};
    assign din[0]         = bus.req0_data;
    assign din[1]         = bus.req1_data;
    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.tx_wr      = tx_wr_q;
    assign bus.tx_byte    = tx_byte_q;

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] wptr;
        logic [AW-1:0] rptr;
        logic [CW-1:0] count;

        // Ready comes from the registered count only, so it never depends on this cycle's pop.
        assign ready[i] = (count != FULL);
        assign empty[i] = (count == '0);
        assign push[i]  = valid[i] & ready[i];
        assign head[i]  = mem[rptr];

        // NOTE: the storage array has no reset; an entry is only read once the count says it was written.
        always_ff @(posedge clk) begin
            if (push[i]) mem[wptr] <= din[i];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push[i]) wptr <= wptr + AW'(1);
                if (pop[i])  rptr <= rptr + AW'(1);
                case ({push[i], pop[i]})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel = empty[0];
        if (!empty[0] && !empty[1]) sel = ~last_grant;
    end

    assign load = (state == IDLE) && (empty != 2'b11);
    assign pop  = {load & sel, load & ~sel};

    always_comb begin
        after_frame = IDLE;
`ifdef UART_ARB_CRLF_EN
        if (tx_byte_q == 8'h0D) after_frame = CRLF;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 2'b00;
        end else begin
            ovf <= ovf | (valid & ~ready);
        end
    end

    // A reset mid-frame abandons the frame; its late tx_done lands in IDLE and is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_wr_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            busy       <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        tx_byte_q  <= head[sel];
                        grant      <= sel;
                        last_grant <= sel;
                        tx_wr_q    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    tx_wr_q <= 1'b0;
                    state   <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.tx_done) begin
                        state <= after_frame;
                        busy  <= (after_frame != IDLE);
                    end else if (bus.tx_active) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        state <= after_frame;
                        busy  <= (after_frame != IDLE);
                    end
                end
`ifdef UART_ARB_CRLF_EN
                CRLF: begin
                    tx_byte_q <= 8'h0A;
                    tx_wr_q   <= 1'b1;
                    state     <= SEND;
                end
`endif
                default: begin
                    tx_wr_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, scored against
// a queue-based model of the two FIFOs, the round-robin rule and the optional CR->CRLF insertion.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int DEPTH    = 4;
    localparam int AW       = 2;
    localparam int M_NORMAL = 0;
    localparam int M_EARLY  = 1;
    localparam int M_HANG   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [1:0] ovf;
    logic       grant;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .ovf   (ovf),
        .grant (grant)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_fail = 0, n_total = 0, cyc = 0;

    // Reference model: per-channel queues, last winner, last byte sent, sticky overflow.
    logic [7:0] q0[$], q1[$];
    logic       m_last, m_grant, expect_lf;
    logic [7:0] m_byte;
    logic [1:0] m_ovf;
    int         n_pop = 0, n_acc = 0;

    // uart_tx responder and transmission log.
    int         mode = M_NORMAL, frame_len = 10, t = 0;
    bit         in_frame = 0, done_now = 0, rand_len = 0;
    logic [7:0] sent_b[$];
    logic       sent_g[$];
    int         wr_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit p0, input logic [7:0] b0, input bit p1, input logic [7:0] b1);
        bit   a0, a1, ch;
        bus.req0_valid = p0;
        bus.req0_data  = b0;
        bus.req1_valid = p1;
        bus.req1_data  = b1;
        a0 = p0 && (q0.size() < DEPTH);
        a1 = p1 && (q1.size() < DEPTH);
        if (p0 && !a0) m_ovf[0] = 1'b1;
        if (p1 && !a1) m_ovf[1] = 1'b1;
        done_now      = 0;
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        if (in_frame) begin
            t++;
            if (mode == M_NORMAL) begin
                if (t >= 2 && t <= frame_len + 1) bus.tx_active = 1'b1;
                else if (t == frame_len + 2) begin
                    bus.tx_done = 1'b1; in_frame = 0; done_now = 1;
                end
            end else if (mode == M_EARLY) begin
                if (t == 2) begin bus.tx_done = 1'b1; in_frame = 0; done_now = 1; end
            end else begin
                if (t >= 2) bus.tx_active = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (bus.tx_wr === 1'b1) begin
            check("wr_has_source", 32'(expect_lf || q0.size() != 0 || q1.size() != 0), 32'd1);
            if (expect_lf) begin
                m_byte    = 8'h0A;
                expect_lf = 1'b0;
            end else if (q0.size() != 0 || q1.size() != 0) begin
                if (q0.size() != 0 && q1.size() != 0) ch = !m_last;
                else                                  ch = (q0.size() == 0);
                if (!ch) m_byte = q0.pop_front();
                else     m_byte = q1.pop_front();
                m_last  = ch;
                m_grant = ch;
                n_pop++;
`ifdef UART_ARB_CRLF_EN
                expect_lf = (m_byte == 8'h0D);
`endif
            end
            sent_b.push_back(bus.tx_byte);
            sent_g.push_back(grant);
            wr_cyc.push_back(cyc);
            in_frame = 1;
            t = 0;
            if (rand_len) frame_len = $urandom_range(1, 6);
        end
        if (a0) q0.push_back(b0);
        if (a1) q1.push_back(b1);
        n_acc += int'(a0) + int'(a1);
        check("tx_byte", 32'(bus.tx_byte), 32'(m_byte));
        check("grant", 32'(grant), 32'(m_grant));
        check("req0_ready", 32'(bus.req0_ready), 32'(q0.size() != DEPTH));
        check("req1_ready", 32'(bus.req1_ready), 32'(q1.size() != DEPTH));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        m_last = 1'b1; m_grant = 1'b0; m_byte = 8'h00; m_ovf = 2'b00; expect_lf = 1'b0;
        in_frame = 0; t = 0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_data = 8'h00; bus.req1_data = 8'h00;
        bus.tx_active = 1'b0; bus.tx_done = 1'b0;
        check("rst_tx_wr", 32'(bus.tx_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_byte", 32'(bus.tx_byte), 32'h00);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready0", 32'(bus.req0_ready), 32'd1);
        check("rst_ready1", 32'(bus.req1_ready), 32'd1);
    endtask

    task automatic run_sends(input int target, input int budget);
        int k = 0;
        while (sent_b.size() < target && k < budget) begin idle(1); k++; end
        check("sends_reached", 32'(sent_b.size() >= target), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        done_now = 0;
        while (!done_now && k < budget) begin idle(1); k++; end
        check("tx_done_seen", 32'(done_now), 32'd1);
    endtask

    initial begin : main
        int         base, gap, budget;
        logic [7:0] rr_b[4];
        logic       rr_g[4];
        logic [7:0] cr_b[3];
        logic [7:0] r0, r1;

        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_data = 8'h00; bus.req1_data = 8'h00;
        bus.tx_active = 1'b0; bus.tx_done = 1'b0;

        // Reset then idle
        do_reset();
        idle(3);
        check("idle_tx_wr", 32'(bus.tx_wr), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Single byte: push at E, tx_wr high from E+1 to E+2
        step(1'b1, 8'h41, 1'b0, 8'h00);
        check("single_e_tx_wr", 32'(bus.tx_wr), 32'd0);
        idle(1);
        check("single_e1_tx_wr", 32'(bus.tx_wr), 32'd1);
        check("single_e1_busy", 32'(busy), 32'd1);
        check("single_byte", 32'(bus.tx_byte), 32'h41);
        check("single_grant", 32'(grant), 32'd0);
        idle(1);
        check("single_e2_tx_wr", 32'(bus.tx_wr), 32'd0);
        wait_done(40);
        check("single_busy_fall", 32'(busy), 32'd0);

        // Round-robin from a fresh reset: 11,21,12,22 with grants 0,1,0,1
        do_reset();
        frame_len = 3;
        base = sent_b.size();
        step(1'b1, 8'h11, 1'b1, 8'h21);
        step(1'b1, 8'h12, 1'b1, 8'h22);
        run_sends(base + 4, 200);
        wait_done(40);
        rr_b = '{8'h11, 8'h21, 8'h12, 8'h22};
        rr_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            if (base + k < sent_b.size()) begin
                check("rr_byte", 32'(sent_b[base + k]), 32'(rr_b[k]));
                check("rr_grant", 32'(sent_g[base + k]), 32'(rr_g[k]));
                if (k > 0) check("rr_gap", 32'(wr_cyc[base + k] - wr_cyc[base + k - 1]), 32'(frame_len + 3));
            end
        end
        check("rr_busy_end", 32'(busy), 32'd0);

        // Early tx_done with tx_active never high: next tx_wr three edges after the previous one
        do_reset();
        mode = M_EARLY;
        base = sent_b.size();
        step(1'b1, 8'hA1, 1'b0, 8'h00);
        step(1'b1, 8'hA2, 1'b0, 8'h00);
        check("early_first_wr", 32'(bus.tx_wr), 32'd1);
        idle(2);
        check("early_done_seen", 32'(done_now), 32'd1);
        check("early_busy_drop", 32'(busy), 32'd0);
        idle(1);
        check("early_second_wr", 32'(bus.tx_wr), 32'd1);
        check("early_second_byte", 32'(bus.tx_byte), 32'hA2);
        gap = (sent_b.size() == base + 2) ? wr_cyc[base + 1] - wr_cyc[base] : -1;
        check("early_gap", 32'(gap), 32'd3);
        wait_done(20);
        mode = M_NORMAL;

        // Overflow on ch1 with the frame hung: one in flight, four queued, sixth dropped
        do_reset();
        mode = M_HANG;
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 8'(8'h60 + i));
        check("ovf_flags", 32'(ovf), 32'b10);
        check("ovf_ready1", 32'(bus.req1_ready), 32'd0);
        check("ovf_ready0", 32'(bus.req0_ready), 32'd1);
        check("ovf_in_flight", 32'(bus.tx_byte), 32'h60);
        check("ovf_busy", 32'(busy), 32'd1);
        idle(3);
        check("ovf_sticky", 32'(ovf), 32'b10);

        // Reset while tx_wr is high: outputs drop without waiting for an edge
        do_reset();
        mode = M_NORMAL;
        frame_len = 4;
        step(1'b1, 8'h55, 1'b0, 8'h00);
        idle(1);
        check("midrst_wr_before", 32'(bus.tx_wr), 32'd1);
        do_reset();
        idle(20);
        check("midrst_quiet_wr", 32'(bus.tx_wr), 32'd0);
        check("midrst_quiet_busy", 32'(busy), 32'd0);

        // CR handling
        do_reset();
        frame_len = 3;
        base = sent_b.size();
        step(1'b1, 8'h0D, 1'b0, 8'h00);
        step(1'b1, 8'h33, 1'b0, 8'h00);
`ifdef UART_ARB_CRLF_EN
        cr_b = '{8'h0D, 8'h0A, 8'h33};
        run_sends(base + 3, 200);
        wait_done(40);
        for (int k = 0; k < 3; k++)
            if (base + k < sent_b.size()) begin
                check("crlf_byte", 32'(sent_b[base + k]), 32'(cr_b[k]));
                check("crlf_grant", 32'(sent_g[base + k]), 32'd0);
            end
`else
        cr_b = '{8'h0D, 8'h33, 8'h00};
        run_sends(base + 2, 200);
        wait_done(40);
        for (int k = 0; k < 2; k++)
            if (base + k < sent_b.size()) check("cr_byte", 32'(sent_b[base + k]), 32'(cr_b[k]));
        idle(5);
        check("cr_no_extra", 32'(sent_b.size() - base), 32'd2);
`endif

        // Random traffic against the model, then drain
        do_reset();
        rand_len = 1;
        n_pop = 0;
        n_acc = 0;
        for (int i = 0; i < 600; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            step($urandom_range(0, 3) == 0, r0, $urandom_range(0, 2) == 0, r1);
        end
        budget = 0;
        while ((q0.size() != 0 || q1.size() != 0 || in_frame || expect_lf) && budget < 1000) begin
            idle(1);
            budget++;
        end
        check("rand_drained", 32'(q0.size() + q1.size()), 32'd0);
        check("rand_all_sent", 32'(n_pop), 32'(n_acc));
        idle(3);
        check("rand_busy_end", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_tx transmitter between two byte producers: channel 0 (UART RX echo) and channel 1 (keyboard key codes). Each channel has a small internal FIFO. A round-robin scheduler pops one byte at a time, pulses tx_wr to uart_tx, and waits for the frame's tx_done before scheduling the next byte. The block sits in main between the producers and uart_tx and drives uart_tx's tx_wr and tx_byte inputs.

Parameters:
DEPTH, 4, entries per channel FIFO; must be a power of 2, minimum 2
AW, 2, FIFO pointer width; must equal log2(DEPTH)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  channel 0 byte strobe
req0_data  in  8  channel 0 byte
req0_ready  out  1  channel 0 FIFO not full
req1_valid  in  1  channel 1 byte strobe
req1_data  in  8  channel 1 byte
req1_ready  out  1  channel 1 FIFO not full
tx_wr  out  1  one-cycle start pulse to uart_tx
tx_byte  out  8  byte presented to uart_tx; held stable until tx_done
tx_active  in  1  uart_tx frame in progress
tx_done  in  1  uart_tx one-cycle end-of-frame pulse
busy  out  1  high in any state other than IDLE
ovf  out  2  sticky per-channel overflow flags; bit i is channel i
grant  out  1  channel of the byte currently or last sent

Behaviour:
- Interface decided: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset, asynchronous and taking effect immediately, including mid-frame:
  - Both FIFOs are emptied.
  - Outputs: tx_wr=0, tx_byte=8'h00, busy=0, ovf=2'b00, grant=0.
  - FSM goes to IDLE.
  - Internal last_grant resets to 1, so channel 0 wins the first tie.
  - Any uart_tx frame in flight is abandoned. Its later tx_done is harmless because the FSM is in IDLE.
- Each FIFO:
  - Holds a count 0..DEPTH. reqN_ready = (countN != DEPTH), combinational from the registered count.
  - Push occurs when reqN_valid && reqN_ready at a clock edge.
  - If reqN_valid && !reqN_ready, the byte is dropped and ovf[N] is set. ovf stays set until reset.
  - Read and write pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave the count unchanged and keep the data correct.
- FSM states:
  - IDLE: if either FIFO is non-empty, select a channel:
    - Only one non-empty: that channel.
    - Both non-empty: the channel != last_grant.
    - Then on the same edge: pop the head into tx_byte, set grant and last_grant, assert tx_wr, go to SEND.
  - SEND: tx_wr high for exactly this one cycle. Then deassert and go to WAIT_START.
  - WAIT_START: go to WAIT_DONE when tx_active=1. If tx_done=1 arrives first, go straight to IDLE.
  - WAIT_DONE: on tx_done=1, go to IDLE. tx_byte is held throughout.
- Latency:
  - A byte pushed into an empty FIFO while in IDLE, on edge E, is popped on edge E+1.
  - tx_wr is high between E+1 and E+2.
  - After tx_done, the next tx_wr follows 2 edges later (back to IDLE, then the load edge).
- Fairness: with both channels continuously non-empty, grants strictly alternate 0,1,0,1,...
- Simultaneous events:
  - A push to the FIFO selected in IDLE in the same cycle is kept.
  - The pop takes the older head.
  - An empty FIFO cannot be popped, so a push to an empty FIFO is granted on the following edge.
- busy = (state != IDLE), registered.

Optional Feature:
UART_ARB_CRLF_EN:
- Defined: after any frame whose tx_byte==8'h0D completes (tx_done), the FSM enters an extra CRLF state instead of IDLE.
  - CRLF loads tx_byte=8'h0A, pulses tx_wr, then follows SEND/WAIT_START/WAIT_DONE as normal.
  - No FIFO pop occurs for the inserted byte. grant and last_grant are unchanged.
  - Arbitration resumes only after the LF frame completes.
- Not defined: bytes are sent verbatim. The CRLF state and its logic are absent.

Test Plan:
- Reset then idle: rst_n low, then high, no requests -> tx_wr=0, busy=0, ovf=00, req0_ready=req1_ready=1; reassert rst_n mid-frame -> tx_wr and busy drop immediately.
- Single byte: push 8'h41 on ch0 at edge E -> tx_wr high one cycle after E+1, tx_byte=8'h41, grant=0; model tx_active for 10 cycles then tx_done -> busy falls the next edge.
- Round-robin: preload ch0 with 11,12 and ch1 with 21,22 in the same cycles -> send order 11,21,12,22, with grant 0,1,0,1.
- Overflow: hold tx_done low, push 6 bytes to ch1 with DEPTH=4 -> first byte is in flight, 4 are queued, 6th dropped; ovf=2'b10, req1_ready=0; ch0 unaffected.
- Early tx_done: tx_done pulses the cycle after SEND with tx_active never high -> FSM returns to IDLE, next byte issued 2 edges later.
- CRLF (macro defined): push 8'h0D then 8'h33 on ch0 -> sent bytes 0D,0A,33; no pop for the 0A; without the macro -> 0D,33.
